// File: rtl/data_mem_unit.sv
// Byte-addressable load/store data memory for the femtoRV32 LSU; word storage with byte lanes.
// Latency: response valid one cycle after accept (two cycles for a split misaligned access).
// Backpressure: one request in flight; req_ready low until the response is taken via rsp_ready.
// Build option: define DMEM_MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module data_mem_unit #(
    parameter int ADDR_W  = 8,
    parameter bit INIT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int WIDX_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WIDX_W;

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
    typedef enum logic [1:0] {IDLE = 2'd0, SPLIT = 2'd1, RESP = 2'd2} state_t;
`else
    localparam bit SPLIT_EN = 1'b0;
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

    state_t state;

    // Power-up image of one word; contents are left at zero when no image is requested.
    function automatic logic [31:0] init_word(input int w);
        logic [31:0] v;
        v = 32'd0;
        if (INIT_EN) begin
            case (w)
                0:       v = 32'd17;
                1:       v = 32'd9;
                2:       v = 32'd25;
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    // Load result from a byte-aligned window: low bytes selected, then sign or zero extended.
    function automatic logic [31:0] extend(input logic [31:0] win, input logic [1:0] size,
                                           input logic sgn);
        logic [31:0] v;
        case (size)
            2'b00:   v = win;
            2'b01:   v = {{16{sgn & win[15]}}, win[15:0]};
            2'b10:   v = {{24{sgn & win[7]}}, win[7:0]};
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Request decode
    logic [1:0]        req_off;
    logic [WIDX_W-1:0] req_idx;
    logic [7:0]        span;
    logic [7:0]        req_mask;   // byte lanes over the addressed word and the next one
    logic              req_mis;
    logic              req_bad;
    logic [31:0]       acc_win;

    // Single write port shared by beat 0 (in IDLE) and beat 1 (in SPLIT)
    logic              wr_en;
    logic [WIDX_W-1:0] wr_idx;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;

    logic [31:0]       mem_q [DEPTH];

`ifdef DMEM_MISALIGN_SPLIT_EN
    // State carried from beat 0 to beat 1 of a split access
    logic [1:0]        cap_off;
    logic [1:0]        cap_size;
    logic              cap_signed;
    logic              cap_write;
    logic [31:0]       cap_lo;
    logic [WIDX_W-1:0] hi_idx;
    logic [3:0]        hi_mask;
    logic [31:0]       hi_data;
    logic [63:0]       split_cat;
    logic [31:0]       split_win;
`endif

    // Storage: one register per word, byte-lane writes, no reset so contents survive rst_n.
    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        logic [31:0] word = init_word(w);

        // Commit the enabled byte lanes when this word is the target of the active beat.
        always_ff @(posedge clk) begin
            if (wr_en && wr_idx == WIDX_W'(w)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_mask[b]) word[8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end

        assign mem_q[w] = word;
    end

    // Decode the incoming request: lane mask, misalignment, and the aligned-read window.
    always_comb begin
        req_off = req_addr[1:0];
        req_idx = req_addr[ADDR_W-1:2];
        case (req_size)
            2'b00:   span = 8'h0F;
            2'b01:   span = 8'h03;
            2'b10:   span = 8'h01;
            default: span = 8'h00;
        endcase
        req_mask = span << req_off;
        req_mis  = |req_mask[7:4];
        req_bad  = (req_size == 2'b11);
        acc_win  = mem_q[req_idx] >> {req_off, 3'b000};
    end

    // Select which beat drives the write port this cycle.
    always_comb begin
        wr_en   = (state == IDLE) && req_valid && req_write && !req_bad &&
                  (SPLIT_EN || !req_mis);
        wr_idx  = req_idx;
        wr_mask = req_mask[3:0];
        wr_data = req_wdata << {req_off, 3'b000};
`ifdef DMEM_MISALIGN_SPLIT_EN
        if (state == SPLIT) begin
            wr_en   = cap_write;
            wr_idx  = hi_idx;
            wr_mask = hi_mask;
            wr_data = hi_data;
        end
`endif
    end

`ifdef DMEM_MISALIGN_SPLIT_EN
    // Beat-1 read window spans the captured low word and the live upper word.
    always_comb begin
        split_cat = {mem_q[hi_idx], cap_lo};
        split_win = split_cat[{1'b0, cap_off, 3'b000} +: 32];
    end

    // Capture request fields and the upper-word lanes at accept for use in SPLIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_off    <= 2'd0;
            cap_size   <= 2'd0;
            cap_signed <= 1'b0;
            cap_write  <= 1'b0;
            cap_lo     <= 32'd0;
            hi_idx     <= '0;
            hi_mask    <= 4'd0;
            hi_data    <= 32'd0;
        end else if (state == IDLE && req_valid) begin
            cap_off    <= req_off;
            cap_size   <= req_size;
            cap_signed <= req_signed;
            cap_write  <= req_write;
            cap_lo     <= mem_q[req_idx];
            hi_idx     <= req_idx + WIDX_W'(1);
            hi_mask    <= req_mask[7:4];
            hi_data    <= req_wdata >> (6'd32 - {1'b0, req_off, 3'b000});
        end
    end
`endif

    // Control FSM with registered handshake outputs and response payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (req_bad || (req_mis && !SPLIT_EN)) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
`ifdef DMEM_MISALIGN_SPLIT_EN
                        else if (req_mis) begin
                            state   <= SPLIT;
                            rsp_err <= 1'b0;
                        end
`endif
                        else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= req_write ? 32'd0 : extend(acc_win, req_size, req_signed);
                        end
                    end
                end
`ifdef DMEM_MISALIGN_SPLIT_EN
                SPLIT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= cap_write ? 32'd0 : extend(split_win, cap_size, cap_signed);
                end
`endif
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
